// File: rtl/dmareq.sv
`default_nettype none
// ============================================================================
// dmareq : queues DMA jobs and sequences them onto dreq_/eop_ handshake.
// Optional watchdog enabled by defining DMAREQ_TIMEOUT_EN.   Rev 1.0
// ============================================================================
module dmareq #(
  parameter int AW      = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          jvalid,
  input  logic [AW-1:0] jsaddr,
  input  logic [AW-1:0] jdaddr,
  input  logic [1:0]    jmode,
  output logic          jready,
  output logic [AW-1:0] dsaddr,
  output logic [AW-1:0] ddaddr,
  output logic [1:0]    dmode,
  output logic          dreq_,
  input  logic          eop_,
  output logic          busy,
  output logic [7:0]    done_cnt,
  output logic          err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  if (DEPTH < 2 || DEPTH > 16 || TIMEOUT < 1) begin : g_param_check
    $error("dmareq: illegal DEPTH or TIMEOUT");
  end

  logic [AW-1:0] mem_s [DEPTH];
  logic [AW-1:0] mem_d [DEPTH];
  logic [1:0]    mem_m [DEPTH];

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q;
  logic [AW-1:0] dsaddr_q, ddaddr_q;
  logic [1:0]    dmode_q;
  logic          dreq_q;
  logic [7:0]    done_q;
  logic          w_push, w_pop;

  assign jready = (count_q != CW'(DEPTH));
  assign w_push = jvalid && jready;
  assign w_pop  = (state_q == IDLE) && (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_s[wr_ptr_q] <= jsaddr;
      mem_d[wr_ptr_q] <= jdaddr;
      mem_m[wr_ptr_q] <= jmode;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

`ifdef DMAREQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_q;
  logic          err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      dsaddr_q <= '0;
      ddaddr_q <= '0;
      dmode_q  <= '0;
      dreq_q   <= 1'b1;
      done_q   <= '0;
`ifdef DMAREQ_TIMEOUT_EN
      wd_q     <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            dsaddr_q <= mem_s[rd_ptr_q];
            ddaddr_q <= mem_d[rd_ptr_q];
            dmode_q  <= mem_m[rd_ptr_q];
            dreq_q   <= 1'b0;
            state_q  <= REQ;
`ifdef DMAREQ_TIMEOUT_EN
            wd_q     <= '0;
`endif
          end
        end
        REQ: begin
          // A completion on the terminal watchdog cycle still counts as done.
          if (!eop_) begin
            dreq_q  <= 1'b1;
            done_q  <= done_q + 8'd1;
            state_q <= GAP;
          end
`ifdef DMAREQ_TIMEOUT_EN
          else if (wd_q == TW'(TIMEOUT - 1)) begin
            dreq_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= GAP;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
`endif
        end
        GAP: begin
          if (eop_) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dsaddr   = dsaddr_q;
  assign ddaddr   = ddaddr_q;
  assign dmode    = dmode_q;
  assign dreq_    = dreq_q;
  assign done_cnt = done_q;
  assign busy     = (state_q != IDLE) || (count_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_dmareq.sv
`default_nettype none
// ============================================================================
// tb_dmareq : directed self-checking bench for dmareq.   Rev 1.0
// ============================================================================
module tb_dmareq;

  logic        clk = 1'b0;
  logic        reset;
  logic        jvalid;
  logic [15:0] jsaddr, jdaddr;
  logic [1:0]  jmode;
  logic        jready;
  logic [15:0] dsaddr, ddaddr;
  logic [1:0]  dmode;
  logic        dreq_;
  logic        eop_;
  logic        busy;
  logic [7:0]  done_cnt;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  dmareq #(.AW(16), .DEPTH(4), .TIMEOUT(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .jvalid   (jvalid),
    .jsaddr   (jsaddr),
    .jdaddr   (jdaddr),
    .jmode    (jmode),
    .jready   (jready),
    .dsaddr   (dsaddr),
    .ddaddr   (ddaddr),
    .dmode    (dmode),
    .dreq_    (dreq_),
    .eop_     (eop_),
    .busy     (busy),
    .done_cnt (done_cnt),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic push(input logic [15:0] s, input logic [15:0] d, input logic [1:0] m);
    jvalid = 1'b1;
    jsaddr = s;
    jdaddr = d;
    jmode  = m;
    tick();
    jvalid = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    jvalid = 1'b0;
    jsaddr = '0;
    jdaddr = '0;
    jmode  = '0;
    eop_   = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_jready", 32'(jready), 32'd1);
    check("rst_dsaddr", 32'(dsaddr), 32'd0);
    check("rst_ddaddr", 32'(ddaddr), 32'd0);
    check("rst_dmode",  32'(dmode),  32'd0);
    check("rst_dreq",   32'(dreq_),  32'd1);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done_cnt), 32'd0);
    check("rst_err",    32'(err),    32'd0);

    // Single job: two-cycle latency, completion, return to idle
    push(16'h0100, 16'h0200, 2'd2);
    check("j1_busy_after_push", 32'(busy), 32'd1);
    check("j1_dreq_after_push", 32'(dreq_), 32'd1);
    tick();
    check("j1_dreq_low", 32'(dreq_), 32'd0);
    check("j1_dsaddr",   32'(dsaddr), 32'h0100);
    check("j1_ddaddr",   32'(ddaddr), 32'h0200);
    check("j1_dmode",    32'(dmode),  32'd2);
    eop_ = 1'b0;
    tick();
    eop_ = 1'b1;
    check("j1_dreq_high", 32'(dreq_), 32'd1);
    check("j1_done",      32'(done_cnt), 32'd1);
    check("j1_busy_gap",  32'(busy), 32'd1);
    check("j1_dsaddr_hold", 32'(dsaddr), 32'h0100);
    tick();
    check("j1_busy_idle", 32'(busy), 32'd0);

    // Five back-to-back jobs into a depth-4 queue
    do_reset();
    jvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      jsaddr = 16'(32'h1000 + i);
      jdaddr = 16'(32'h2000 + i);
      jmode  = 2'(i);
      tick();
    end
    check("full_jready", 32'(jready), 32'd0);
    check("full_busy",   32'(busy),   32'd1);
    jsaddr = 16'hDEAD;
    jdaddr = 16'hBEEF;
    jmode  = 2'd3;
    tick();
    jvalid = 1'b0;
    check("full_reject_jready", 32'(jready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      check("seq_dreq_low", 32'(dreq_),  32'd0);
      check("seq_dsaddr",   32'(dsaddr), 32'h1000 + k);
      check("seq_ddaddr",   32'(ddaddr), 32'h2000 + k);
      check("seq_dmode",    32'(dmode),  32'(k % 4));
      eop_ = 1'b0;
      tick();
      eop_ = 1'b1;
      check("seq_dreq_high1", 32'(dreq_), 32'd1);
      check("seq_done",       32'(done_cnt), 32'(k + 1));
      tick();
      check("seq_dreq_high2", 32'(dreq_), 32'd1);
      if (k < 4) tick();
    end
    check("seq_done_final", 32'(done_cnt), 32'd5);
    check("seq_busy_final", 32'(busy),     32'd0);
    check("seq_jready_final", 32'(jready), 32'd1);
    check("seq_err", 32'(err), 32'd0);

    // eop_ held low for three cycles counts once
    push(16'h3333, 16'h4444, 2'd1);
    tick();
    check("hold_dreq_low", 32'(dreq_), 32'd0);
    eop_ = 1'b0;
    tick();
    check("hold_done_1", 32'(done_cnt), 32'd6);
    tick();
    check("hold_busy_gap", 32'(busy), 32'd1);
    check("hold_dreq_gap", 32'(dreq_), 32'd1);
    tick();
    check("hold_done_3", 32'(done_cnt), 32'd6);
    check("hold_busy_gap2", 32'(busy), 32'd1);
    eop_ = 1'b1;
    tick();
    check("hold_busy_idle", 32'(busy), 32'd0);
    check("hold_done_final", 32'(done_cnt), 32'd6);

    // Asynchronous reset mid-REQ with two jobs queued
    jvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      jsaddr = 16'(32'h7000 + i);
      jdaddr = 16'(32'h8000 + i);
      jmode  = 2'd0;
      tick();
    end
    jvalid = 1'b0;
    check("ar_dreq_low", 32'(dreq_), 32'd0);
    check("ar_busy",     32'(busy),  32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_dreq_async", 32'(dreq_), 32'd1);
    check("ar_busy_async", 32'(busy),  32'd0);
    check("ar_done_async", 32'(done_cnt), 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ar_no_req", 32'(dreq_), 32'd1);
    end
    check("ar_busy_after", 32'(busy), 32'd0);

`ifdef DMAREQ_TIMEOUT_EN
    // Watchdog: eight REQ cycles without eop_, then the next job runs
    do_reset();
    jvalid = 1'b1;
    jsaddr = 16'h5000; jdaddr = 16'h5100; jmode = 2'd1;
    tick();
    jsaddr = 16'h6000; jdaddr = 16'h6100; jmode = 2'd2;
    tick();
    jvalid = 1'b0;
    check("to_dreq_low", 32'(dreq_), 32'd0);
    for (int i = 1; i < 8; i++) begin
      tick();
      check("to_dreq_hold", 32'(dreq_), 32'd0);
    end
    tick();
    check("to_dreq_rise", 32'(dreq_), 32'd1);
    check("to_err",       32'(err),   32'd1);
    check("to_done",      32'(done_cnt), 32'd0);
    tick();
    tick();
    check("to_next_dreq",   32'(dreq_),  32'd0);
    check("to_next_dsaddr", 32'(dsaddr), 32'h6000);
    eop_ = 1'b0;
    tick();
    eop_ = 1'b1;
    check("to_next_done", 32'(done_cnt), 32'd1);
    check("to_err_sticky", 32'(err), 32'd1);
    tick();
`endif

    // 256 completions wrap the counter
    do_reset();
    for (int j = 0; j < 256; j++) begin
      push(16'(j), 16'(j + 1), 2'(j));
      tick();
      eop_ = 1'b0;
      tick();
      eop_ = 1'b1;
      tick();
      if (j == 254) check("wrap_255", 32'(done_cnt), 32'd255);
    end
    check("wrap_0",    32'(done_cnt), 32'd0);
    check("wrap_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmareq.md
# dmareq

I/O-side DMA request generator that sits directly upstream of the DMA controller and feeds its `dsaddr`/`ddaddr`/`dmode`/`dreq_` inputs. It queues transfer jobs (source address, destination address, mode) pushed by the I/O device in a small FIFO. It presents one job at a time to the DMA controller, holding `dreq_` low until the controller signals completion on `eop_`. It also counts completed jobs.

## Interface

- `AW`, default 16: address width; equals `BUS_ADDR_WIDTH` at instantiation.
- `DEPTH`, default 4: job queue depth; power of two, 2..16.
- `TIMEOUT`, default 255: watchdog limit in cycles (only with `DMAREQ_TIMEOUT_EN`).

Ports:

- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `jvalid`  in  1  job push strobe.
- `jsaddr`  in  AW  job source address.
- `jdaddr`  in  AW  job destination address.
- `jmode`  in  2  job transfer mode.
- `jready`  out  1  queue not full; push accepted on an edge where `jvalid && jready`.
- `dsaddr`  out  AW  current job source address, to DMA controller.
- `ddaddr`  out  AW  current job destination address.
- `dmode`  out  2  current job mode.
- `dreq_`  out  1  active-low DMA request.
- `eop_`  in  1  active-low end-of-transfer from DMA controller.
- `busy`  out  1  job in flight or queue non-empty.
- `done_cnt`  out  8  completed-job counter.
- `err`  out  1  sticky timeout flag.

## Operation

- The FIFO holds `DEPTH` entries of {saddr, daddr, mode}, with registered read/write pointers and an occupancy count of log2(DEPTH)+1 bits.
- `jready` = (count != DEPTH), taken from the registered count. When the queue is full, `jready` stays 0 even on a cycle where a pop occurs.
- A push and a pop on the same edge leave the count unchanged; both pointers advance and wrap modulo DEPTH.
- FSM states: IDLE, REQ, GAP.
  - IDLE: if count != 0, pop the head into the `dsaddr`/`ddaddr`/`dmode` registers and go to REQ. Otherwise stay in IDLE.
  - REQ: `dreq_`=0. When `eop_`==0 is sampled, set `dreq_`=1, increment `done_cnt`, and go to GAP.
  - GAP: `dreq_`=1. Stay in GAP until `eop_`==1 is sampled, then go to IDLE. Minimum one cycle in GAP.
- `dsaddr`/`ddaddr`/`dmode` change only on the IDLE→REQ edge. They are stable for the entire REQ and GAP period.
- `done_cnt` is 8-bit and wraps 255→0.
- `busy` = (state != IDLE) || (count != 0).
- `eop_` is ignored in IDLE.

## Timing

- Reset values: `jready`=1, `dsaddr`=0, `ddaddr`=0, `dmode`=0, `dreq_`=1, `busy`=0, `done_cnt`=0, `err`=0; state IDLE; queue empty.
- Push to empty queue at edge N: `busy`=1 after N. The job is popped at N+1, so `dreq_`=0 after N+1, a two-cycle latency.
- `eop_` low sampled at edge M: `dreq_`=1 after M. The next job's `dreq_` goes low no earlier than edge M+2 (GAP → IDLE → REQ).
- Back-to-back jobs therefore have at least two `dreq_`-high cycles between them.
- Reset asserted mid-REQ: `dreq_` goes to 1 asynchronously and queued jobs are discarded.

## Configuration

- `DMAREQ_TIMEOUT_EN` defined:
  - A watchdog counter clears on entry to REQ and increments every REQ cycle.
  - If it reaches `TIMEOUT` with no `eop_` seen, the block sets `dreq_`=1, sets `err`=1 (sticky until reset), leaves `done_cnt` unchanged, and goes to GAP.
  - If `eop_` low coincides with the terminal count, the job counts as completed and `err` is not set.
- `DMAREQ_TIMEOUT_EN` undefined: no watchdog, REQ waits indefinitely, and `err` is tied to 0.

## Test plan

- Reset, then push one job {s=0x0100, d=0x0200, m=2}: `dreq_` low two cycles after the push with outputs matching. Pull `eop_` low for one cycle: `dreq_`=1 next cycle, `done_cnt`=1, `busy`=0 two cycles later.
- Push 5 jobs back-to-back with DEPTH=4 and `eop_` held high: `jready` falls when the queue is full. Jobs appear in order with ≥2 `dreq_`-high cycles between them. After 5 `eop_` pulses, `done_cnt`=5.
- Hold `eop_` low for 3 cycles: block stays in GAP until `eop_` returns high. `done_cnt` increments once only.
- Assert `reset` asynchronously mid-REQ with 2 jobs queued: `dreq_`=1 and `busy`=0 without waiting for a clock edge. After release, no request occurs.
- With `DMAREQ_TIMEOUT_EN`, TIMEOUT=8, never assert `eop_`: `dreq_` rises after 8 REQ cycles, `err`=1, `done_cnt`=0, and the next job proceeds.
- Drive 256 jobs to completion: `done_cnt` wraps to 0.
